// File: rtl/me_job_sequencer.sv
// Job sequencer for the motion-estimation core: loads the reference block and the search window,
// runs the core, and returns the minimum SAD (or a timeout marker) over a valid/ready result port.
module me_job_sequencer #(
  parameter int DATA_WIDTH      = 8,
  parameter int SW_MEMORY_DEPTH = 961,
  parameter int RB_MEMORY_DEPTH = 256,
  parameter int MAX_DATA_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES  = 4096,
  localparam int RB_AW  = $clog2(RB_MEMORY_DEPTH),
  localparam int SW_AW  = $clog2(SW_MEMORY_DEPTH),
  localparam int CNT_W  = $clog2(((SW_MEMORY_DEPTH > RB_MEMORY_DEPTH) ? SW_MEMORY_DEPTH
                                                                        : RB_MEMORY_DEPTH) + 1),
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                      in_clk,
  input  logic                      in_rst,
  input  logic                      in_start,
  input  logic                      in_abort,
  output logic                      out_busy,
  input  logic                      in_pix_valid,
  input  logic [DATA_WIDTH-1:0]     in_pix_data,
  output logic                      out_pix_ready,
  output logic                      out_rb_write_en,
  output logic [RB_AW-1:0]          out_rb_write_addr,
  output logic                      out_sw_write_en,
  output logic [SW_AW-1:0]          out_sw_write_addr,
  output logic [DATA_WIDTH-1:0]     out_write_data,
  output logic                      out_me_rst,
  output logic                      out_me_enable,
  input  logic                      in_me_done,
  input  logic [MAX_DATA_WIDTH-1:0] in_me_min_sad,
  output logic                      out_res_valid,
  input  logic                      in_res_ready,
  output logic [MAX_DATA_WIDTH-1:0] out_res_sad,
  output logic                      out_res_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_RB,
    S_LOAD_SW,
    S_CORE_RST,
    S_WAIT_DONE,
    S_RESULT
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [TO_W-1:0]   tcnt, tcnt_nxt;
  logic              beat_p0;
  logic              capture_done, capture_timeout;

  logic                  rb_we_p1, sw_we_p1;
  logic [RB_AW-1:0]      rb_addr_p1;
  logic [SW_AW-1:0]      sw_addr_p1;
  logic [DATA_WIDTH-1:0] wdata_p1;

  assign out_pix_ready = (state == S_LOAD_RB) || (state == S_LOAD_SW);
  assign out_busy      = (state != S_IDLE);
  assign out_me_rst    = (state == S_CORE_RST);
  assign out_me_enable = (state == S_WAIT_DONE);
  assign out_res_valid = (state == S_RESULT);
  assign beat_p0       = in_pix_valid && out_pix_ready;

  // Abort only matters once a job is running, so a start/abort collision in IDLE starts the job.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    tcnt_nxt        = tcnt;
    capture_done    = 1'b0;
    capture_timeout = 1'b0;
    if (in_abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      tcnt_nxt  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_start) begin
            state_nxt = S_LOAD_RB;
            cnt_nxt   = '0;
          end
        end
        S_LOAD_RB: begin
          if (beat_p0) begin
            if (cnt == CNT_W'(RB_MEMORY_DEPTH - 1)) begin
              state_nxt = S_LOAD_SW;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        S_LOAD_SW: begin
          if (beat_p0) begin
            if (cnt == CNT_W'(SW_MEMORY_DEPTH - 1)) begin
              state_nxt = S_CORE_RST;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        S_CORE_RST: begin
          state_nxt = S_WAIT_DONE;
          tcnt_nxt  = '0;
        end
        S_WAIT_DONE: begin
          if (in_me_done) begin
            state_nxt    = S_RESULT;
            capture_done = 1'b1;
          end else if (tcnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_nxt       = S_RESULT;
            capture_timeout = 1'b1;
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
        S_RESULT: begin
          if (in_res_ready) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      tcnt  <= tcnt_nxt;
    end
  end

  // p0 -> p1: accepted beat becomes a memory write one cycle later; an aborted beat never writes.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      rb_we_p1   <= 1'b0;
      sw_we_p1   <= 1'b0;
      rb_addr_p1 <= '0;
      sw_addr_p1 <= '0;
      wdata_p1   <= '0;
    end else begin
      rb_we_p1 <= beat_p0 && (state == S_LOAD_RB) && !in_abort;
      sw_we_p1 <= beat_p0 && (state == S_LOAD_SW) && !in_abort;
      if (beat_p0) begin
        rb_addr_p1 <= RB_AW'(cnt);
        sw_addr_p1 <= SW_AW'(cnt);
        wdata_p1   <= in_pix_data;
      end
    end
  end

  assign out_rb_write_en   = rb_we_p1;
  assign out_sw_write_en   = sw_we_p1;
  assign out_rb_write_addr = rb_addr_p1;
  assign out_sw_write_addr = sw_addr_p1;
  assign out_write_data    = wdata_p1;

  // Result is held until the consumer takes it; a timeout reports an all-ones SAD.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      out_res_sad     <= '0;
      out_res_timeout <= 1'b0;
    end else if (capture_done) begin
      out_res_sad     <= in_me_min_sad;
      out_res_timeout <= 1'b0;
    end else if (capture_timeout) begin
      out_res_sad     <= '1;
      out_res_timeout <= 1'b1;
    end
  end

endmodule
